jtdd_sdram_mux: RTL

//  Parametrised N-slot SDRAM read arbiter, replacing the fixed-slot ROM fetcher in game tops.

---
 rtl/jtdd_sdram_mux_pkg.sv | 15 +
 rtl/jtdd_slot_cache.sv | 41 ++++
 rtl/jtdd_sdram_mux.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/jtdd_sdram_mux_pkg.sv
// rtl/jtdd_sdram_mux_pkg.sv - arbiter state encoding and slot-index width helper
package jtdd_sdram_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DATA = 2'd2
   } state_t;

   // A single slot still needs one index bit so that the index registers stay legal.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jtdd_slot_cache.sv
// rtl/jtdd_slot_cache.sv - one-word read cache for a single requester slot
module jtdd_slot_cache #(
   parameter int AW = 22,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] dout,
   output logic          hit
);

   logic [AW-1:0] cached_addr;
   logic          valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         cached_addr <= '0;
         dout        <= '0;
         valid       <= 1'b0;
      end else begin
         if (we) begin
            cached_addr <= wr_addr;
            dout        <= wr_data;
         end
         // Invalidation wins over a same-cycle fill.
         if (clr)
            valid <= 1'b0;
         else if (we)
            valid <= 1'b1;
      end
   end

   assign hit = cs && valid && (cached_addr == addr);

endmodule

// File: rtl/jtdd_sdram_mux.sv
// rtl/jtdd_sdram_mux.sv - N-slot SDRAM read arbiter with per-slot one-word caches
module jtdd_sdram_mux
   import jtdd_sdram_mux_pkg::*;
#(
   parameter int               SLOTS     = 6,
   parameter int               AW        = 22,
   parameter int               DW        = 32,
   parameter int               RR        = 0,
   parameter logic [SLOTS-1:0] BLANK_MSK = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                LVBL,
   input  logic                downloading,
   input  logic                loop_rst,
   input  logic [SLOTS-1:0]    slot_cs,
   input  logic [SLOTS*AW-1:0] slot_addr,
   output logic [SLOTS*DW-1:0] slot_dout,
   output logic [SLOTS-1:0]    slot_ok,
   output logic                sdram_req,
   output logic [AW-1:0]       sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic [DW-1:0]       data_read,
   output logic                refresh_en,
   output logic                ready
);

   localparam int IW = idx_width(SLOTS);
   localparam int CW = IW + 1;

   state_t           state;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    last;
   logic [IW-1:0]    win;
   logic [IW-1:0]    start;
   logic [CW-1:0]    cand;
   logic             found;
   logic             any_miss;
   logic             clr;
   logic             we;
   logic [SLOTS-1:0] hit;
   logic [SLOTS-1:0] miss;
   logic [SLOTS-1:0] we_slot;
   logic [AW-1:0]    addr_a [SLOTS];

   assign clr = downloading | loop_rst;

   // A fill may arrive together with the ack; data landing in IDLE belongs to an aborted read.
   assign we = !clr && data_rdy &&
               ((state == ST_WAIT_DATA) || (state == ST_WAIT_ACK && sdram_ack));

   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      assign addr_a[i]  = slot_addr[i*AW +: AW];
      assign we_slot[i] = we && (idx == IW'(i));
      assign miss[i]    = slot_cs[i] && !hit[i] && !(BLANK_MSK[i] && LVBL);

      jtdd_slot_cache #(
         .AW(AW),
         .DW(DW)
      ) u_cache (
         .clk     (clk),
         .rst     (rst),
         .clr     (clr),
         .cs      (slot_cs[i]),
         .addr    (addr_a[i]),
         .we      (we_slot[i]),
         .wr_addr (sdram_addr),
         .wr_data (data_read),
         .dout    (slot_dout[i*DW +: DW]),
         .hit     (hit[i])
      );
   end

   assign slot_ok  = hit;
   assign any_miss = |miss;
   assign ready    = !downloading && !any_miss;

   // Round-robin starts the search one past the last served slot; fixed priority always starts at 0.
   always_comb begin
      start = '0;
      cand  = '0;
      win   = '0;
      found = 1'b0;
      if (RR != 0 && last != IW'(SLOTS-1))
         start = last + 1'b1;
      for (int k = 0; k < SLOTS; k++) begin
         cand = {1'b0, start} + CW'(k);
         if (cand >= CW'(SLOTS))
            cand = cand - CW'(SLOTS);
         if (!found && miss[cand[IW-1:0]]) begin
            found = 1'b1;
            win   = cand[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         last       <= IW'(SLOTS-1);
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         refresh_en <= 1'b1;
      end else begin
         refresh_en <= (state == ST_IDLE) && !any_miss;
         if (clr) begin
            state     <= ST_IDLE;
            sdram_req <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (any_miss) begin
                     idx        <= win;
                     last       <= win;
                     sdram_addr <= addr_a[win];
                     sdram_req  <= 1'b1;
                     state      <= ST_WAIT_ACK;
                  end
               end
               ST_WAIT_ACK: begin
                  if (sdram_ack) begin
                     sdram_req <= 1'b0;
                     state     <= data_rdy ? ST_IDLE : ST_WAIT_DATA;
                  end
               end
               ST_WAIT_DATA: begin
                  if (data_rdy)
                     state <= ST_IDLE;
               end
               default: begin
                  state     <= ST_IDLE;
                  sdram_req <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
